// File: rtl/clkdiv_pkg.sv
// Shared types and limits for the slow-clock divider controller.
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} clkdiv_state_t;
  localparam int MIN_DIVISOR = 2;
endpackage

// File: rtl/clock_divider_controller_if.sv
// Divisor configuration port: valid/ready transfer plus a reject pulse.
interface clock_divider_controller_if #(parameter int WIDTH = 16) ();
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_divisor, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_divisor, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_core.sv
// Divide counter with registered divided clock and tick; wrap marks the last
// cycle of a period so the controller can swap divisors on a period boundary.
module clkdiv_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_div_q, tick_q;

  assign wrap_o = run_i && (count_q == divisor_i - WIDTH'(1));

  // load restarts the period when a new divisor takes effect
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (!run_i || load_i || wrap_o) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_div_q <= run_i && (count_q < (divisor_i >> 1));
      tick_q    <= run_i && (count_q == '0);
    end
  end

  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;
endmodule

// File: rtl/clock_divider_controller.sv
// Run/stop sequencing and staged divisor updates around clkdiv_core, so the
// divided clock never shows a truncated or stretched period.
module clock_divider_controller
  import clkdiv_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEFAULT_DIVISOR = 2
) (
  input  logic                       clockIN,
  input  logic                       reset,
  input  logic                       enable,
  clock_divider_controller_if.slave  cfg,
  output logic                       clockOUT,
  output logic                       tick,
  output logic [WIDTH-1:0]           active_divisor,
  output logic                       running
);
  clkdiv_state_t    state_q;
  logic [WIDTH-1:0] active_q, pend_div_q;
  logic             pend_vld_q, cfg_err_q;
  logic             xfer, bad_div, wrap, run, load;

  assign xfer    = cfg.cfg_valid && !pend_vld_q;
  assign bad_div = cfg.cfg_divisor < WIDTH'(MIN_DIVISOR);
  assign run     = (state_q != IDLE);
  assign load    = wrap && pend_vld_q;

  always_ff @(posedge clockIN) begin
    if (reset) begin
      state_q    <= IDLE;
      active_q   <= WIDTH'(DEFAULT_DIVISOR);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= xfer && bad_div;

      // enable wins over the wrap in STOP so a re-request never loses a period
      case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= STOP;
        STOP:    if (enable) state_q <= RUN;
                 else if (wrap) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (state_q == IDLE) begin
        // a divisor staged on the final wrap lands here, before any restart
        if (pend_vld_q) begin
          active_q   <= pend_div_q;
          pend_vld_q <= 1'b0;
        end else if (xfer && !bad_div) begin
          active_q <= cfg.cfg_divisor;
        end
      end else begin
        if (load) begin
          active_q   <= pend_div_q;
          pend_vld_q <= 1'b0;
        end
        if (xfer && !bad_div) begin
          pend_div_q <= cfg.cfg_divisor;
          pend_vld_q <= 1'b1;
        end
      end
    end
  end

  clkdiv_core #(.WIDTH(WIDTH)) u_core (
    .clk_i     (clockIN),
    .rst_i     (reset),
    .run_i     (run),
    .load_i    (load),
    .divisor_i (active_q),
    .clk_div_o (clockOUT),
    .tick_o    (tick),
    .wrap_o    (wrap)
  );

  assign cfg.cfg_ready = !pend_vld_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign active_divisor = active_q;
  assign running        = run;
endmodule

// File: tb/tb_clock_divider_controller.sv
// Random enable/config/reset traffic against a period-level reference model.
module tb_clock_divider_controller;
  localparam int W   = 16;
  localparam int DEF = 4;

  logic         clk = 1'b0;
  logic         rst, en;
  logic         clk_out, tick_o, running_o;
  logic [W-1:0] act_o;

  clock_divider_controller_if #(.WIDTH(W)) cfg_if ();

  clock_divider_controller #(.WIDTH(W), .DEFAULT_DIVISOR(DEF)) dut (
    .clockIN        (clk),
    .reset          (rst),
    .enable         (en),
    .cfg            (cfg_if.slave),
    .clockOUT       (clk_out),
    .tick           (tick_o),
    .active_divisor (act_o),
    .running        (running_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position within the current period, active/pending divisor.
  bit m_on, m_stopping, m_pv;
  int m_pos, m_d, m_pd;
  bit e_clk, e_tick, e_err;

  task automatic model_step(input bit r, input bit e, input bit v, input int d);
    bit xfer, last;
    if (r) begin
      m_on = 0; m_stopping = 0; m_pv = 0; m_pos = 0; m_d = DEF; m_pd = 0;
      e_clk = 0; e_tick = 0; e_err = 0;
      return;
    end
    xfer  = v && !m_pv;
    e_err = xfer && (d < 2);
    if (m_on) begin
      e_clk  = m_pos < (m_d / 2);
      e_tick = (m_pos == 0);
      last   = (m_pos == m_d - 1);
      if (m_stopping) begin
        if (e) m_stopping = 0;
        else if (last) m_on = 0;
      end else if (!e) begin
        m_stopping = 1;
      end
      if (last) begin
        m_pos = 0;
        if (m_pv) begin m_d = m_pd; m_pv = 0; end
      end else begin
        m_pos = m_pos + 1;
      end
      if (xfer && d >= 2) begin m_pd = d; m_pv = 1; end
    end else begin
      e_clk = 0; e_tick = 0;
      if (m_pv) begin m_d = m_pd; m_pv = 0; end
      else if (xfer && d >= 2) m_d = d;
      if (e) begin m_on = 1; m_stopping = 0; end
    end
  endtask

  task automatic compare_all();
    chk("clockOUT", int'(clk_out), int'(e_clk));
    chk("tick", int'(tick_o), int'(e_tick));
    chk("cfg_err", int'(cfg_if.cfg_err), int'(e_err));
    chk("running", int'(running_o), int'(m_on));
    chk("cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pv));
    chk("active_divisor", int'(act_o), m_d);
  endtask

  task automatic drive(input bit r, input bit e, input bit v, input int d);
    rst = r; en = e;
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_divisor = W'(d);
    model_step(r, e, v, d);
  endtask

  initial begin
    drive(1, 0, 0, 0);
    // reset, then hold enable with the default divisor
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); compare_all();
      drive(1, 0, 0, 0);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); compare_all();
      drive(0, 1, 0, 0);
    end
    // offer 6, then rejected 1 and 0 later
    @(negedge clk); compare_all(); drive(0, 1, 1, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); compare_all(); drive(0, 1, 0, 0);
    end
    @(negedge clk); compare_all(); drive(0, 1, 1, 1);
    @(negedge clk); compare_all(); drive(0, 1, 1, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, e, v;
      int d;
      @(negedge clk); compare_all();
      r = ($urandom_range(0, 299) == 0);
      e = en;
      if ($urandom_range(0, 19) == 0) e = ~en;
      v = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 9);
      drive(r, e, v, d);
    end
    @(negedge clk); compare_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
